// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the unified instruction/data memory responder:
//   - RV32I funct3 access-size codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
//   - responder FSM state enumeration
//   - is_legal_size(): true for the five size codes the responder serves
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Codes 011, 110 and 111 have no RV32I load/store meaning here.
    function automatic logic is_legal_size(input logic [2:0] size);
        return (size == MEM_B)  || (size == MEM_H)  || (size == MEM_W) ||
               (size == MEM_BU) || (size == MEM_HU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering between the core's right-aligned
// data and the 32-bit memory word.
// Ports:
//   i_size      RV32I funct3 access size
//   i_addr_lo   byte offset within the word (addr[1:0])
//   i_wdata     right-aligned store data from the core
//   i_rword     raw 32-bit word read from the array
//   o_be        per-byte write enable for a store
//   o_wword     store data shifted into its byte lanes
//   o_rdata     load data, right-aligned and sign/zero extended
//   o_misalign  halfword on odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [4:0]  w_shift;
    logic [31:0] w_rshift;

    assign w_shift  = {i_addr_lo, 3'b000};
    assign w_rshift = i_rword >> w_shift;
    assign o_wword  = i_wdata << w_shift;

    always_comb begin
        o_be       = 4'b0000;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            MEM_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
            end
            MEM_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_rdata = {24'h0, w_rshift[7:0]};
            end
            MEM_H: begin
                o_be       = 4'b0011 << i_addr_lo;
                o_rdata    = {{16{w_rshift[15]}}, w_rshift[15:0]};
                o_misalign = i_addr_lo[0];
            end
            MEM_HU: begin
                o_be       = 4'b0011 << i_addr_lo;
                o_rdata    = {16'h0, w_rshift[15:0]};
                o_misalign = i_addr_lo[0];
            end
            MEM_W: begin
                o_be       = 4'b1111;
                o_rdata    = i_rword;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_be    = 4'b0000;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder for the multicycle RISC-V core. Accepts
// one request in IDLE, waits LATENCY cycles, commits the access on the edge
// that enters RESP and holds the response until the core takes it.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  / req_ready   request handshake (ready only in IDLE)
//   req_addr   byte address
//   req_write  1 = store, 0 = load/fetch
//   req_size   RV32I funct3 size code
//   req_wdata  right-aligned store data
//   rsp_valid  / rsp_ready   response handshake
//   rsp_rdata  extended load data, 0 for stores and errors
//   rsp_err    access rejected (illegal size, misaligned, out of range)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_commit;
    logic [3:0]  r_count;

    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]      w_addr;
    logic             w_write;
    logic [2:0]       w_size;
    logic [31:0]      w_wdata;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_rword;
    logic             w_oob;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wword;
    logic [31:0]      w_load_data;
    logic             w_misalign;

    // With LATENCY 0 the commit edge is also the accept edge, so the access
    // must be decoded from the live request inputs while still in IDLE.
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_write = (r_state == IDLE) ? req_write : r_write;
    assign w_size  = (r_state == IDLE) ? req_size  : r_size;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_index = w_addr[IDX_W+1:2];
    assign w_rword = r_mem[w_index];
    assign w_oob   = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err   = !is_legal_size(w_size) || w_misalign || w_oob;

    mem_lane_align u_align (
        .i_size     (w_size),
        .i_addr_lo  (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_load_data),
        .o_misalign (w_misalign)
    );

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_commit marks the edge that enters RESP.
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_next_state = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = RESP;
                    w_commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture, wait-state counter and the held response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
            r_addr  <= 32'h0;
            r_write <= 1'b0;
            r_size  <= 3'b000;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_count <= LAT_INIT;
            end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_write) ? 32'h0 : w_load_data;
            end
        end
    end

    // Array write at commit only; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

endmodule
